// File: rtl/pwm_multi_pkg.sv
// Shared definitions for the multi-channel PWM: register map, mode encoding
// and the helper that sizes the register address bus.
package pwm_multi_pkg;

    localparam int ADDR_PERIOD = 0;
    localparam int ADDR_MODE   = 1;
    localparam int ADDR_PRESC  = 2;
    localparam int ADDR_DUTY0  = 3;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTRE = 1'b1
    } mode_e;

    // Period, mode and prescale sit below the per-channel duty registers.
    function automatic int addr_w(input int channels);
        return $clog2(channels + ADDR_DUTY0);
    endfunction

endpackage

// File: rtl/pwm_multi_timebase.sv
// Shared PWM timebase: prescaler, edge/centre counter and the period
// boundary that drives shadow loading and the period_end pulse.
module pwm_multi_timebase
    import pwm_multi_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               en,
    input  logic [WIDTH-1:0]   period_stg,
    input  logic               mode_stg,
    input  logic [PRESC_W-1:0] presc_stg,
    output logic [WIDTH-1:0]   count,
    output logic               load,
    output logic               period_end
);

    logic [WIDTH-1:0]   period_sh;
    mode_e              mode_sh;
    logic [PRESC_W-1:0] presc_sh;
    logic [PRESC_W-1:0] presc_cnt;
    logic               dir_down;
    logic               tick;
    logic               boundary;

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        tick     = (presc_cnt == presc_sh);
        boundary = 1'b0;
        if (tick) begin
            if (mode_sh == MODE_EDGE)
                boundary = (count >= period_sh);
            else
                boundary = (period_sh == '0) || (dir_down && (count == '0));
        end
    end

    // Shadows are transparent while disabled so the first enabled period
    // already runs with the latest staged values.
    assign load = !en || boundary;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            period_sh  <= '0;
            mode_sh    <= MODE_EDGE;
            presc_sh   <= '0;
            presc_cnt  <= '0;
            count      <= '0;
            dir_down   <= 1'b0;
            period_end <= 1'b0;
        end else if (!en) begin
            period_sh  <= period_stg;
            mode_sh    <= mode_e'(mode_stg);
            presc_sh   <= presc_stg;
            presc_cnt  <= '0;
            count      <= '0;
            dir_down   <= 1'b0;
            period_end <= 1'b0;
        end else begin
            period_end <= boundary;
            if (tick) begin
                presc_cnt <= '0;
                if (boundary) begin
                    period_sh <= period_stg;
                    mode_sh   <= mode_e'(mode_stg);
                    presc_sh  <= presc_stg;
                    dir_down  <= 1'b0;
                    // The trough value was just spent, so a continuing centre
                    // sweep resumes at 1; a mode change restarts from 0.
                    if (mode_sh == MODE_CENTRE && mode_e'(mode_stg) == MODE_CENTRE
                        && period_stg != '0)
                        count <= WIDTH'(1);
                    else
                        count <= '0;
                end else if (mode_sh == MODE_EDGE) begin
                    count <= count + WIDTH'(1);
                end else if (!dir_down) begin
                    if (count >= period_sh) begin
                        dir_down <= 1'b1;
                        count    <= count - WIDTH'(1);
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end else begin
                    count <= count - WIDTH'(1);
                end
            end else begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: staged register writes, shadow duties loaded
// at the period boundary, and registered per-channel compare outputs.
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int                  WIDTH    = 16,
    parameter int                  CHANNELS = 4,
    parameter int                  PRESC_W  = 8,
    parameter logic [CHANNELS-1:0] POL_MASK = {CHANNELS{1'b0}}
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        EN,
    input  logic                        wr_en,
    input  logic [addr_w(CHANNELS)-1:0] wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    output logic [CHANNELS-1:0]         pwm_out,
    output logic                        period_end
);

    localparam int AW = addr_w(CHANNELS);

    logic [WIDTH-1:0]    period_stg;
    logic                mode_stg;
    logic [PRESC_W-1:0]  presc_stg;
    logic [WIDTH-1:0]    duty_stg [CHANNELS];
    logic [WIDTH-1:0]    duty_sh  [CHANNELS];
    logic [WIDTH-1:0]    count;
    logic                load;
    logic [CHANNELS-1:0] active;

    // NOTE: the duty arrays are plain flops, not RAM, so they are reset like any register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            period_stg <= '0;
            mode_stg   <= 1'b0;
            presc_stg  <= '0;
            for (int i = 0; i < CHANNELS; i++)
                duty_stg[i] <= '0;
        end else if (wr_en) begin
            if (wr_addr == AW'(ADDR_PERIOD)) period_stg <= wr_data;
            if (wr_addr == AW'(ADDR_MODE))   mode_stg   <= wr_data[0];
            if (wr_addr == AW'(ADDR_PRESC))  presc_stg  <= wr_data[PRESC_W-1:0];
            for (int i = 0; i < CHANNELS; i++)
                if (wr_addr == AW'(ADDR_DUTY0 + i))
                    duty_stg[i] <= wr_data;
        end
    end

    pwm_multi_timebase #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .CLK        (CLK),
        .nRST       (nRST),
        .en         (EN),
        .period_stg (period_stg),
        .mode_stg   (mode_stg),
        .presc_stg  (presc_stg),
        .count      (count),
        .load       (load),
        .period_end (period_end)
    );

    // A write landing on the load edge is seen here as the old staging value.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < CHANNELS; i++)
                duty_sh[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < CHANNELS; i++)
                duty_sh[i] <= duty_stg[i];
        end
    end

    always_comb begin
        active = '0;
        for (int i = 0; i < CHANNELS; i++)
            active[i] = (count < duty_sh[i]);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            pwm_out <= POL_MASK;
        else
            pwm_out <= (EN ? active : '0) ^ POL_MASK;
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus queues per-period expectations,
// a negedge monitor measures each period and compares on period_end.
module tb_pwm_multi;

    localparam logic [3:0] POL = 4'b0010;

    typedef struct {
        bit chk;
        int gap;
        int hi [4];
    } exp_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        EN;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  pwm_out;
    logic        period_end;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q [$];
    int   mon_gap = 0;
    int   mon_hi [4];

    pwm_multi #(
        .WIDTH    (16),
        .CHANNELS (4),
        .PRESC_W  (8),
        .POL_MASK (POL)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .EN         (EN),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pwm_out    (pwm_out),
        .period_end (period_end)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = 3'(addr);
        wr_data = 16'(data);
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic expect_dc();
        exp_t e;
        e.chk = 1'b0;
        e.gap = 0;
        for (int i = 0; i < 4; i++) e.hi[i] = 0;
        exp_q.push_back(e);
    endtask

    task automatic expect_periods(input int n, input int gap,
                                  input int h0, input int h1, input int h2, input int h3);
        exp_t e;
        e.chk   = 1'b1;
        e.gap   = gap;
        e.hi[0] = h0;
        e.hi[1] = h1;
        e.hi[2] = h2;
        e.hi[3] = h3;
        for (int k = 0; k < n; k++) exp_q.push_back(e);
    endtask

    // Raise EN and count cycles to the first period_end; counter must start at 0.
    task automatic measure_first_pe(input int expected, input string name);
        int n;
        n  = 0;
        EN = 1'b1;
        do begin
            step(1);
            n++;
        end while (!period_end && n < 100);
        check(name, n, expected);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            step(1);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: one sample per cycle; a period's window closes on its period_end.
    initial begin : monitor
        logic [3:0] act;
        exp_t       e;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                mon_gap = 0;
                for (int i = 0; i < 4; i++) mon_hi[i] = 0;
            end else begin
                act = pwm_out ^ POL;
                mon_gap++;
                for (int i = 0; i < 4; i++) mon_hi[i] += int'(act[i]);
                if (period_end) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_period_end: got 1 expected 0 at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.chk) begin
                            check("period_gap", mon_gap, e.gap);
                            for (int i = 0; i < 4; i++)
                                check($sformatf("ch%0d_high_cycles", i), mon_hi[i], e.hi[i]);
                        end
                    end
                    mon_gap = 0;
                    for (int i = 0; i < 4; i++) mon_hi[i] = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        nRST    = 1'b0;
        EN      = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        // Reset state: outputs at inactive level.
        step(2);
        check("reset_pwm_out", int'(pwm_out), int'(POL));
        check("reset_period_end", int'(period_end), 0);
        @(negedge CLK);
        nRST = 1'b1;
        step(1);
        check("disabled_pwm_out", int'(pwm_out), int'(POL));

        // Edge mode, period 9: duty 3, 0 (0 %), 10 (100 %), 9 (equal to period).
        wr(0, 9);
        wr(3, 3);
        wr(4, 0);
        wr(5, 10);
        wr(6, 9);
        step(1);
        expect_dc();
        measure_first_pe(10, "edge_first_period");
        expect_periods(3, 10, 3, 0, 10, 9);
        wait_drain();

        // Shadowing: now at count 1 of period A.
        // A: write 7 mid-period, old duty 3 holds. B: 7.
        // Write 2 on B's boundary edge: C keeps 7, D takes 2.
        expect_periods(1, 10, 3, 0, 10, 9);
        expect_periods(2, 10, 7, 0, 10, 9);
        expect_periods(1, 10, 2, 0, 10, 9);
        step(3);
        wr(3, 7);
        step(14);
        wr(3, 2);
        wait_drain();

        // Prescaler 3, period 4: counter moves every 4 cycles, 20-cycle period.
        EN = 1'b0;
        wr(0, 4);
        wr(2, 3);
        wr(3, 2);
        wr(4, 0);
        wr(5, 5);
        wr(6, 4);
        step(1);
        expect_dc();
        measure_first_pe(20, "presc_first_period");
        expect_periods(3, 20, 8, 0, 20, 16);
        wait_drain();

        // EN low mid-period: outputs inactive on the next cycle.
        step(5);
        EN = 1'b0;
        step(1);
        check("en_low_pwm_out", int'(pwm_out), int'(POL));
        check("en_low_period_end", int'(period_end), 0);

        // Centre mode, period 5, staged while disabled. First period runs
        // 0..5..0 (11 ticks); afterwards 1,2,3,4,5,4,3,2,1,0 (10 ticks).
        // Duty 2 is active for counts 1,0,1 around the trough: 3 cycles.
        wr(2, 0);
        wr(1, 1);
        wr(0, 5);
        wr(3, 0);
        wr(4, 2);
        wr(5, 6);
        wr(6, 5);
        step(1);
        expect_dc();
        measure_first_pe(11, "centre_first_period");
        expect_periods(3, 10, 0, 3, 10, 9);
        wait_drain();

        // Asynchronous reset mid-count.
        step(2);
        #2;
        nRST = 1'b0;
        #1;
        check("async_reset_pwm_out", int'(pwm_out), int'(POL));
        check("async_reset_period_end", int'(period_end), 0);
        EN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        step(1);
        check("post_reset_pwm_out", int'(pwm_out), int'(POL));

        // Registers were cleared: reprogram edge mode and confirm count starts at 0.
        wr(0, 9);
        wr(3, 3);
        step(1);
        expect_dc();
        measure_first_pe(10, "post_reset_first_period");
        expect_periods(2, 10, 3, 0, 0, 0);
        wait_drain();

        EN = 1'b0;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
